alu_operand_b_sel: RTL and testbench
====================================

// Module: alu_operand_b_sel
// PURPOSE
// - Registered, parametrised operand-B selector for the accumulator datapath ALU; sits between the register/immediate sources and the ALU B input.
// - Generalises the fixed 4-way B mux: N sources, programmable constant slot (replaces hardwired 2), valid/ready handshake with a 1-entry skid buffer.
// - Detects out-of-range selects instead of holding a stale value; counts them for debug.
// PARAMETERS
// - WIDTH       16  data width of every source and of mux_out
// - NSRC        4   number of selectable slots; slot 0 = constant register, slots 1..NSRC-1 = src_flat lanes
// - SELW        3   width of op; must satisfy 2**SELW >= NSRC
// - CONST_RST   2   reset value of the constant register
// - ERRW        8   width of the saturating error counter
// PORTS
// - clk            in   1                 clock, all state on rising edge
// - reset_n        in   1                 synchronous reset, active-low
// - in_valid       in   1                 op/src_flat valid this cycle
// - in_ready       out  1                 block can accept; = !skid_full
// - op             in   SELW              slot select
// - src_flat       in   (NSRC-1)*WIDTH    lane k-1 at [k*WIDTH-1:(k-1)*WIDTH] = slot k
// - const_wr_en    in   1                 write constant register
// - const_wr_data  in   WIDTH             new constant value
// - const_val      out  WIDTH             current constant register
// - out_valid      out  1                 mux_out valid
// - out_ready      in   1                 ALU consumes mux_out
// - mux_out        out  WIDTH             selected operand
// - out_op_err     out  1                 delivered word came from op >= NSRC (mux_out = 0)
// - err_count      out  ERRW              saturating count of accepted out-of-range ops
// BEHAVIOUR
// - Reset (reset_n=0 at edge): out_valid=0, skid_full=0, mux_out=0, out_op_err=0, err_count=0, const_val=CONST_RST; in_ready=1 next cycle. Mid-transfer data is dropped.
// - Accept = in_valid & in_ready. Selection computed combinationally at accept; result registered.
// - Latency: accept in cycle n -> mux_out/out_valid in cycle n+1 when output stage empty or draining.
// - Select: op==0 -> const_val; 1<=op<NSRC -> slot op; op>=NSRC -> data 0, err flag 1, err_count+1 (holds at 2**ERRW-1).
// - Output stage: loads when empty or (out_valid & out_ready). If output is stalled (out_valid & !out_ready) and accept occurs, word goes to skid register; in_ready drops next cycle.
// - Skid drain: when out_ready with skid_full, skid word moves to output, skid_full=0; no new accept while skid_full (in_ready=0).
// - Ordering strictly FIFO; no word lost or duplicated; mux_out/out_op_err stable while out_valid & !out_ready.
// - Constant write: const_val updates at edge; an accept in the same cycle uses the OLD constant.
// - Simultaneous skid drain + accept impossible (in_ready=0 when skid_full); simultaneous output drain + accept with skid empty -> new word straight to output.
// - err_count increments only on accepted words, including those stored to skid.
// - in_ready depends only on registered state (no comb path from out_ready).
// TESTING
// - Reset then op=0, in_valid=1, out_ready=1 -> cycle+1 mux_out=0x0002, out_valid=1, in_ready=1.
// - src lanes 1..3 = 0x1111,0x2222,0x3333, op=1,2,3 back-to-back, out_ready=1 -> outputs 0x1111,0x2222,0x3333 on consecutive cycles.
// - const_wr_en=1 data=0xBEEF with accept op=0 same cycle -> output 0x0002; next accept op=0 -> 0xBEEF.
// - out_ready=0, accept op=1 then op=2 -> in_ready=0, out holds 0x1111; raise out_ready -> 0x1111 then 0x2222, in_ready returns 1.
// - op=5 accepted 300 times (ERRW=8) -> mux_out=0, out_op_err=1 each, err_count saturates at 255.
// - Skid full, assert reset_n=0 one cycle -> out_valid=0, in_ready=1, err_count=0, const_val=0x0002.

Source files
------------

// File: rtl/alu_operand_b_sel_if.sv
// Operand-B selector handshake bundle: request side (op/src lanes) and result side (selected word).
interface alu_operand_b_sel_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NSRC  = 4,
    parameter int unsigned SELW  = 3
);
    logic                        in_valid;
    logic                        in_ready;
    logic [SELW-1:0]             op;
    logic [(NSRC-1)*WIDTH-1:0]   src_flat;
    logic                        out_valid;
    logic                        out_ready;
    logic [WIDTH-1:0]            mux_out;
    logic                        out_op_err;

    modport master (
        output in_valid, op, src_flat, out_ready,
        input  in_ready, out_valid, mux_out, out_op_err
    );

    modport slave (
        input  in_valid, op, src_flat, out_ready,
        output in_ready, out_valid, mux_out, out_op_err
    );
endinterface

// File: rtl/alu_operand_b_sel.sv
// Registered N-way operand-B selector with programmable constant slot, skid buffer and
// saturating out-of-range select counter.
module alu_operand_b_sel #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned NSRC      = 4,
    parameter int unsigned SELW      = 3,
    parameter int unsigned CONST_RST = 2,
    parameter int unsigned ERRW      = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    alu_operand_b_sel_if.slave   bus,
    input  logic                 const_wr_en,
    input  logic [WIDTH-1:0]     const_wr_data,
    output logic [WIDTH-1:0]     const_val,
    output logic [ERRW-1:0]      err_count
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             err;
    } word_t;

    localparam logic [ERRW-1:0] ERR_MAX = {ERRW{1'b1}};

    word_t            out_q, out_nxt;
    word_t            skid_q, skid_nxt;
    logic             out_valid_q, out_valid_nxt;
    logic             skid_full_q, skid_full_nxt;
    logic [ERRW-1:0]  err_cnt_q, err_cnt_nxt;
    logic [WIDTH-1:0] const_q, const_nxt;
    word_t            sel;
    logic             accept;
    logic             out_free;

    // Slot decode; constant slot sees the pre-write register value
    always_comb begin
        sel.data = '0;
        sel.err  = 1'b0;
        if (bus.op == '0) begin
            sel.data = const_q;
        end else if (32'(bus.op) >= NSRC) begin
            sel.err = 1'b1;
        end else begin
            for (int unsigned k = 1; k < NSRC; k++) begin
                if (32'(bus.op) == k) begin
                    sel.data = bus.src_flat[k*WIDTH-1 -: WIDTH];
                end
            end
        end
    end

    assign accept   = bus.in_valid & ~skid_full_q;
    assign out_free = ~out_valid_q | bus.out_ready;

    always_comb begin
        out_nxt       = out_q;
        skid_nxt      = skid_q;
        out_valid_nxt = out_valid_q;
        skid_full_nxt = skid_full_q;
        err_cnt_nxt   = err_cnt_q;
        const_nxt     = const_q;

        // Output stage refills from skid first to keep FIFO order
        if (out_free) begin
            if (skid_full_q) begin
                out_nxt       = skid_q;
                out_valid_nxt = 1'b1;
                skid_full_nxt = 1'b0;
            end else if (accept) begin
                out_nxt       = sel;
                out_valid_nxt = 1'b1;
            end else begin
                out_valid_nxt = 1'b0;
            end
        end else if (accept) begin
            skid_nxt      = sel;
            skid_full_nxt = 1'b1;
        end

        if (accept && sel.err && (err_cnt_q != ERR_MAX)) begin
            err_cnt_nxt = err_cnt_q + ERRW'(1);
        end

        if (const_wr_en) begin
            const_nxt = const_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            skid_full_q <= 1'b0;
            err_cnt_q   <= '0;
            const_q     <= WIDTH'(CONST_RST);
        end else begin
            out_q       <= out_nxt;
            skid_q      <= skid_nxt;
            out_valid_q <= out_valid_nxt;
            skid_full_q <= skid_full_nxt;
            err_cnt_q   <= err_cnt_nxt;
            const_q     <= const_nxt;
        end
    end

    assign bus.in_ready   = ~skid_full_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.mux_out    = out_q.data;
    assign bus.out_op_err = out_q.err;
    assign const_val      = const_q;
    assign err_count      = err_cnt_q;

endmodule

// File: tb/tb_alu_operand_b_sel.sv
// Bench for alu_operand_b_sel: directed and random traffic against a 2-deep FIFO reference model.
module tb_alu_operand_b_sel;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned NSRC  = 4;
    localparam int unsigned SELW  = 3;
    localparam int unsigned ERRW  = 8;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             const_wr_en;
    logic [WIDTH-1:0] const_wr_data;
    logic [WIDTH-1:0] const_val;
    logic [ERRW-1:0]  err_count;

    int total = 0;
    int bad   = 0;

    alu_operand_b_sel_if #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW)) bus ();

    alu_operand_b_sel #(
        .WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW), .CONST_RST(2), .ERRW(ERRW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .bus           (bus),
        .const_wr_en   (const_wr_en),
        .const_wr_data (const_wr_data),
        .const_val     (const_val),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;

    // Reference model: in-flight words as a queue (head = presented word, at most 2 held)
    logic [16:0] q[$];
    int          m_err;
    logic [15:0] m_const;
    logic [15:0] lane [1:3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] model_word(input int o);
        if (o == 0)          return {m_const, 1'b0};
        else if (o < NSRC)   return {lane[o], 1'b0};
        else                 return {16'h0000, 1'b1};
    endfunction

    task automatic model_reset();
        q.delete();
        m_err   = 0;
        m_const = 16'h0002;
    endtask

    task automatic check_outputs();
        check("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
        check("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
        check("err_count", 32'(err_count), 32'(m_err));
        check("const_val", 32'(const_val), 32'(m_const));
        if (q.size() > 0) begin
            check("mux_out", 32'(bus.mux_out), 32'(q[0][16:1]));
            check("out_op_err", 32'(bus.out_op_err), 32'(q[0][0]));
        end
    endtask

    // Called at a negedge: check, drive this cycle's inputs, advance model, wait a cycle
    task automatic step(input logic v, input int o, input logic rdy,
                        input logic cwe = 1'b0, input logic [15:0] cwd = 16'h0);
        logic [16:0] w;
        logic        acc;
        check_outputs();
        bus.in_valid  = v;
        bus.op        = SELW'(o);
        bus.src_flat  = {lane[3], lane[2], lane[1]};
        bus.out_ready = rdy;
        const_wr_en   = cwe;
        const_wr_data = cwd;
        acc = v && (q.size() < 2);
        w   = model_word(o);
        if (rdy && q.size() > 0) void'(q.pop_front());
        if (acc) begin
            q.push_back(w);
            if (w[0] && m_err < 255) m_err++;
        end
        if (cwe) m_const = cwd;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.out_ready = 1'b0;
        const_wr_en   = 1'b0;
        const_wr_data = '0;
    endtask

    initial begin
        lane[1] = 16'h1111; lane[2] = 16'h2222; lane[3] = 16'h3333;
        bus.src_flat = '0;
        idle_inputs();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check("rst_mux_out", 32'(bus.mux_out), 32'h0);
        check("rst_out_err", 32'(bus.out_op_err), 32'h0);

        // Constant slot after reset
        step(1, 0, 1);
        check("first_const", 32'(bus.mux_out), 32'h0002);
        step(0, 0, 1);

        // Back-to-back lane selects
        step(1, 1, 1); step(1, 2, 1); step(1, 3, 1); step(0, 0, 1); step(0, 0, 1);

        // Constant write with same-cycle accept uses old value
        step(1, 0, 1, 1'b1, 16'hBEEF);
        check("old_const", 32'(bus.mux_out), 32'h0002);
        step(1, 0, 1);
        check("new_const", 32'(bus.mux_out), 32'hBEEF);
        step(0, 0, 1);

        // Stall fills skid, then drain in order
        step(1, 1, 0); step(1, 2, 0); step(1, 3, 0); step(0, 0, 0);
        check("stall_hold", 32'(bus.mux_out), 32'h1111);
        step(0, 0, 1); step(0, 0, 1); step(0, 0, 1);

        // Out-of-range selects saturate the counter
        for (int i = 0; i < 300; i++) step(1, 5, 1);
        step(0, 0, 1);
        check("err_sat", 32'(err_count), 32'd255);
        step(0, 0, 1);

        // Reset while skid is full
        step(1, 1, 0); step(1, 2, 0); step(0, 0, 0);
        idle_inputs();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        check("rst2_in_ready", 32'(bus.in_ready), 32'h1);
        check("rst2_err", 32'(err_count), 32'h0);
        step(0, 0, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            lane[1] = 16'($urandom); lane[2] = 16'($urandom); lane[3] = 16'($urandom);
            step(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0), 16'($urandom));
        end
        check_outputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
